// File: rtl/mac_table_arbiter_pkg.sv
// mac_table_arbiter_pkg: shared defaults and FSM state encoding for the MAC table arbiter
package mac_table_arbiter_pkg;
  localparam int DEF_PORT_NUM = 4;
  localparam int DEF_SLOTS = 256;
  typedef enum logic [2:0] {IDLE, LEARN, LOOKUP, CAPTURE, RESP} arbState_t;
endpackage

// File: rtl/mac_table_arbiter_if.sv
// mac_table_arbiter_if: requester and MAC table signals between ingress ports and the arbiter
interface mac_table_arbiter_if
  import mac_table_arbiter_pkg::*;
#(
  parameter int pPORT_NUM = DEF_PORT_NUM,
  parameter int pSLOTS = DEF_SLOTS
);
  localparam int PW = $clog2(pPORT_NUM);
  localparam int AW = $clog2(pSLOTS);
  logic [pPORT_NUM-1:0] i_req;
  logic [pPORT_NUM*AW-1:0] i_sa;
  logic [pPORT_NUM*AW-1:0] i_da;
  logic [pPORT_NUM-1:0] o_ack;
  logic [PW-1:0] o_dst_port;
  logic o_drop;
  logic o_busy;
  logic o_tbl_we;
  logic [PW-1:0] o_tbl_port_num;
  logic [AW-1:0] o_tbl_sa;
  logic [AW-1:0] o_tbl_da;
  logic [PW-1:0] i_tbl_port_num;
  modport slave (
    input i_req, i_sa, i_da, i_tbl_port_num,
    output o_ack, o_dst_port, o_drop, o_busy, o_tbl_we, o_tbl_port_num, o_tbl_sa, o_tbl_da
  );
  modport master (
    output i_req, i_sa, i_da, i_tbl_port_num,
    input o_ack, o_dst_port, o_drop, o_busy, o_tbl_we, o_tbl_port_num, o_tbl_sa, o_tbl_da
  );
endinterface

// File: rtl/mac_table_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above rrPtr with wrap
module rr_arbiter #(
  parameter int pPORT_NUM = 4,
  localparam int PW = $clog2(pPORT_NUM)
) (
  input  logic [pPORT_NUM-1:0] req,
  input  logic [PW-1:0]        rrPtr,
  output logic [PW-1:0]        gntIdx,
  output logic                 gntValid
);
  logic [PW-1:0] idx;
  // scan from the farthest offset down so the nearest request to rrPtr wins last
  always_comb begin
    gntIdx = '0;
    gntValid = 1'b0;
    idx = '0;
    for (int i = pPORT_NUM - 1; i >= 0; i--) begin
      idx = rrPtr + PW'(i);
      if (req[idx]) begin
        gntIdx = idx;
        gntValid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_table_arbiter.sv
// mac_table_arbiter: round-robin sharing of the single-port MAC table, learn SA then look up DA
module mac_table_arbiter
  import mac_table_arbiter_pkg::*;
#(
  parameter int pPORT_NUM = DEF_PORT_NUM,
  parameter int pSLOTS = DEF_SLOTS
) (
  input logic iclk,
  input logic i_rst_n,
  mac_table_arbiter_if.slave bus
);
  localparam int PW = $clog2(pPORT_NUM);
  localparam int AW = $clog2(pSLOTS);
  arbState_t state;
  logic [PW-1:0] rrPtr;
  logic [PW-1:0] gntIdx;
  logic [PW-1:0] pick;
  logic pickValid;
  logic [AW-1:0] daLatch;
  logic [pPORT_NUM-1:0] ackMask;
  logic [pPORT_NUM-1:0] reqMasked;
  assign reqMasked = bus.i_req & ~ackMask;
  rr_arbiter #(.pPORT_NUM(pPORT_NUM)) uArb (
    .req(reqMasked),
    .rrPtr(rrPtr),
    .gntIdx(pick),
    .gntValid(pickValid)
  );
  // sequencer: grant, write SA->port, present DA, capture result, pulse ack
  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      rrPtr <= '0;
      gntIdx <= '0;
      daLatch <= '0;
      ackMask <= '0;
      bus.o_ack <= '0;
      bus.o_dst_port <= '0;
      bus.o_drop <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_tbl_we <= 1'b0;
      bus.o_tbl_port_num <= '0;
      bus.o_tbl_sa <= '0;
      bus.o_tbl_da <= '0;
    end else begin
      case (state)
        IDLE: begin
          ackMask <= '0;
          if (pickValid) begin
            state <= LEARN;
            gntIdx <= pick;
            rrPtr <= pick + PW'(1);
            daLatch <= bus.i_da[pick*AW +: AW];
            bus.o_tbl_sa <= bus.i_sa[pick*AW +: AW];
            bus.o_tbl_port_num <= pick;
            bus.o_tbl_we <= 1'b1;
            bus.o_busy <= 1'b1;
          end
        end
        LEARN: begin
          state <= LOOKUP;
          bus.o_tbl_we <= 1'b0;
          bus.o_tbl_da <= daLatch;
        end
        LOOKUP: state <= CAPTURE;
        CAPTURE: begin
          state <= RESP;
          bus.o_dst_port <= bus.i_tbl_port_num;
          bus.o_drop <= bus.i_tbl_port_num == gntIdx;
          bus.o_ack <= pPORT_NUM'(1) << gntIdx;
        end
        RESP: begin
          state <= IDLE;
          ackMask <= bus.o_ack;
          bus.o_ack <= '0;
          bus.o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mac_table_arbiter.md
# mac_table_arbiter

Shares the single-port `MAC_table` between `pPORT_NUM` ingress ports. Each port raises a learn+lookup request carrying its frame's source and destination address. A round-robin arbiter grants one port at a time, and a 5-state FSM sequences the table: write SA→port (learn), then read DA. The FSM then returns the destination port, plus a source-filter drop flag, to the granted requester. The block sits between the ingress port logic and `MAC_table`, and drives all of the table's inputs.

## Interface
Parameters:
- `pPORT_NUM`, 4 — number of switch ports; power of two, ≥2. `PW = $clog2(pPORT_NUM)`.
- `pSLOTS`, 256 — MAC table slots; power of two. `AW = $clog2(pSLOTS)`.

Ports:
- `iclk`  in  1  — single clock; all logic is rising-edge.
- `i_rst_n`  in  1  — asynchronous, active-low reset.
- `i_req`  in  pPORT_NUM  — per-port request level; bit p is port p.
- `i_sa`  in  pPORT_NUM*AW  — per-port source address; port p occupies bits [p*AW +: AW].
- `i_da`  in  pPORT_NUM*AW  — per-port destination address; same packing as `i_sa`.
- `o_ack`  out  pPORT_NUM  — one-hot, single-cycle completion pulse to the granted port.
- `o_dst_port`  out  PW  — lookup result; valid only while `o_ack` is nonzero.
- `o_drop`  out  1  — asserted with `o_ack` when `o_dst_port` equals the requesting port.
- `o_busy`  out  1  — high in every state except IDLE.
- `o_tbl_we`  out  1  — drives `MAC_table.i_write_enable`.
- `o_tbl_port_num`  out  PW  — drives `i_port_num`.
- `o_tbl_sa`  out  AW  — drives `i_MAC_SA`.
- `o_tbl_da`  out  AW  — drives `i_MAC_DA`.
- `i_tbl_port_num`  in  PW  — from `MAC_table.o_port_num`; valid one cycle after `o_tbl_da` is presented.

## Operation
- FSM states: IDLE → LEARN → LOOKUP → CAPTURE → RESP → IDLE. There is no other transition; once granted, a request always completes.
- **IDLE**
  - If the masked request vector is nonzero, grant one port and go to LEARN.
  - Grant rule: the first set bit scanning upward from `rr_ptr`, with wrap-around.
  - On grant, latch `gnt_idx`, the SA and DA of the granted port, and set `rr_ptr = gnt_idx+1` (mod pPORT_NUM).
- **LEARN**
  - `o_tbl_we=1`, `o_tbl_sa=SA`, `o_tbl_port_num=gnt_idx`.
- **LOOKUP**
  - `o_tbl_we=0`, `o_tbl_da=DA`.
- **CAPTURE**
  - Register `i_tbl_port_num` into `o_dst_port`.
  - Register `drop = (i_tbl_port_num == gnt_idx)`.
- **RESP**
  - `o_ack[gnt_idx]=1`; `o_dst_port` and `o_drop` hold their captured values.
- Request handshake:
  - A requester holds `i_req`, SA and DA stable until it sees its `o_ack` bit.
  - A requester deasserts `i_req` no later than the cycle after `o_ack`.
  - The acked port's `i_req` bit is masked for the first IDLE cycle after RESP.
  - SA and DA are sampled only at grant, so changes after grant are ignored.
- `o_tbl_sa`, `o_tbl_da` and `o_tbl_port_num` hold their last values in every state; only `o_tbl_we` qualifies a write.
- No hit/miss detection. An unlearned DA returns whatever the table holds; flood decisions are made downstream.

## Timing
- Reset values: state IDLE; `rr_ptr=0`; every output 0, including `o_tbl_*`.
- Latency, with `i_req` sampled in IDLE at edge t:
  - `o_tbl_we` high in cycle t+1.
  - DA presented in t+2.
  - Table data captured at the end of t+3.
  - `o_ack` high for exactly cycle t+4.
  - IDLE again in t+5.
- Throughput: one request per 5 cycles. The worst-case wait for any port is 5·pPORT_NUM cycles.
- Simultaneous requests: only one grant per IDLE cycle; the others wait. The round-robin pointer prevents starvation.
- Reset mid-operation:
  - The FSM aborts immediately and no `o_ack` is issued for the aborted request.
  - If reset lands during LEARN, the table write is cut short; `o_tbl_we` drops asynchronously.
- DA equal to own SA:
  - LEARN writes before LOOKUP reads, so the lookup returns `gnt_idx`.
  - `o_drop=1`.
- `rr_ptr` wraps from pPORT_NUM-1 to 0.

## Structure
- `header.v` provides `pPORT_NUM` and `pSLOTS` to this block and to `MAC_table`.
- The FSM state localparams are also placed in `header.v`, so benches can probe states by name.
- Sub-module `rr_arbiter`: combinational masked round-robin pick.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: `gnt_idx`, `gnt_valid`.
- Pointer register, FSM and datapath latches live in `mac_table_arbiter`.

## Test plan
- Single request: port 2, SA=0x10, DA=0x10. Expect:
  - `o_tbl_we` pulse at t+1 with `o_tbl_sa`=0x10 and `o_tbl_port_num`=2.
  - `o_ack`=4'b0100 at t+4, with `o_dst_port`=2 and `o_drop`=1.
- Learn then forward: port 1 learns SA=0x20. Port 3 then requests with DA=0x20. Expect:
  - Port 3's ack carries `o_dst_port`=1 and `o_drop`=0.
- All four ports request continuously from reset. Expect:
  - Grants in order 0,1,2,3,0.
  - Acks exactly 5 cycles apart.
- Held request: port 0 holds `i_req` one extra cycle after its ack while port 1 also requests. Expect:
  - The next grant is port 1, not a duplicate for port 0.
- Reset asserted during LOOKUP for port 2. Expect:
  - All outputs 0 immediately and no `o_ack`.
  - After release, a fresh port 0 request is served with `rr_ptr` starting at 0.
- SA/DA changed by the requester after grant. Expect:
  - The table sees the values latched at grant; the result is unaffected.
